// File: rtl/ex_rs.sv
// Reservation station in front of the execute stage: buffers dispatched ops,
// snoops the CDB for pending operands and presents the lowest-index ready entry.
module ex_rs #(
    parameter int DEPTH = 4,
    parameter int TAG_W = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     flush,
    input  logic                     disp_valid,
    output logic                     disp_ready,
    input  logic [9:0]               disp_op,
    input  logic                     disp_is_branch,
    input  logic [31:0]              disp_pc_plus4,
    input  logic [TAG_W-1:0]         disp_dest,
    input  logic                     disp_qj_busy,
    input  logic [TAG_W-1:0]         disp_qj,
    input  logic [31:0]              disp_vj,
    input  logic                     disp_qk_busy,
    input  logic [TAG_W-1:0]         disp_qk,
    input  logic [31:0]              disp_vk,
    input  logic                     cdb_valid,
    input  logic [TAG_W-1:0]         cdb_tag,
    input  logic [31:0]              cdb_value,
    output logic                     iss_valid,
    input  logic                     iss_ready,
    output logic [9:0]               iss_op,
    output logic                     iss_is_branch,
    output logic [31:0]              iss_pc_plus4,
    output logic [31:0]              iss_vj,
    output logic [31:0]              iss_vk,
    output logic [TAG_W-1:0]         iss_dest,
    output logic [$clog2(DEPTH):0]   occupancy
);

    localparam int IDX_W = $clog2(DEPTH);
    localparam int OCC_W = IDX_W + 1;

    typedef struct packed {
        logic             valid;
        logic [9:0]       op;
        logic             is_branch;
        logic [31:0]      pc_plus4;
        logic [TAG_W-1:0] dest;
        logic             qj_busy;
        logic [TAG_W-1:0] qj;
        logic [31:0]      vj;
        logic             qk_busy;
        logic [TAG_W-1:0] qk;
        logic [31:0]      vk;
    } entry_t;

    entry_t ent_q [DEPTH];
    entry_t ent_d [DEPTH];
    entry_t disp_ent;
    entry_t sel_ent;

    logic [DEPTH-1:0] rdy;
    logic [DEPTH-1:0] used;
    logic             full;
    logic             sel_found;
    logic [IDX_W-1:0] sel_idx;
    logic             free_found;
    logic [IDX_W-1:0] free_idx;
    logic             disp_fire;
    logic             iss_fire;
    logic [OCC_W-1:0] occ_cnt;

    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            used[i] = ent_q[i].valid;
            rdy[i]  = ent_q[i].valid & ~ent_q[i].qj_busy & ~ent_q[i].qk_busy;
        end
    end

    // Fixed priority: the first match scanning upward wins, for both issue and allocation.
    always_comb begin
        sel_found  = 1'b0;
        sel_idx    = '0;
        free_found = 1'b0;
        free_idx   = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (rdy[i] && !sel_found) begin
                sel_found = 1'b1;
                sel_idx   = IDX_W'(i);
            end
            if (!used[i] && !free_found) begin
                free_found = 1'b1;
                free_idx   = IDX_W'(i);
            end
        end
    end

    assign full       = &used;
    assign disp_ready = ~full;
    assign disp_fire  = disp_valid & ~full & ~flush;
    assign iss_valid  = sel_found;
    assign iss_fire   = sel_found & iss_ready & ~flush;

    always_comb begin
        disp_ent           = '0;
        disp_ent.valid     = 1'b1;
        disp_ent.op        = disp_op;
        disp_ent.is_branch = disp_is_branch;
        disp_ent.pc_plus4  = disp_pc_plus4;
        disp_ent.dest      = disp_dest;
        disp_ent.qj_busy   = disp_qj_busy;
        disp_ent.qj        = disp_qj;
        disp_ent.vj        = disp_vj;
        disp_ent.qk_busy   = disp_qk_busy;
        disp_ent.qk        = disp_qk;
        disp_ent.vk        = disp_vk;
        // Producer broadcasting in the dispatch cycle would otherwise be missed forever.
        if (cdb_valid && disp_qj_busy && (disp_qj == cdb_tag)) begin
            disp_ent.qj_busy = 1'b0;
            disp_ent.vj      = cdb_value;
        end
        if (cdb_valid && disp_qk_busy && (disp_qk == cdb_tag)) begin
            disp_ent.qk_busy = 1'b0;
            disp_ent.vk      = cdb_value;
        end
    end

    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            ent_d[i] = ent_q[i];
            if (flush) begin
                ent_d[i].valid = 1'b0;
            end else begin
                if (ent_q[i].valid && cdb_valid) begin
                    if (ent_q[i].qj_busy && (ent_q[i].qj == cdb_tag)) begin
                        ent_d[i].qj_busy = 1'b0;
                        ent_d[i].vj      = cdb_value;
                    end
                    if (ent_q[i].qk_busy && (ent_q[i].qk == cdb_tag)) begin
                        ent_d[i].qk_busy = 1'b0;
                        ent_d[i].vk      = cdb_value;
                    end
                end
                if (iss_fire && (sel_idx == IDX_W'(i))) begin
                    ent_d[i].valid = 1'b0;
                end
                if (disp_fire && free_found && (free_idx == IDX_W'(i))) begin
                    ent_d[i] = disp_ent;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                ent_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                ent_q[i] <= ent_d[i];
            end
        end
    end

    always_comb begin
        sel_ent = ent_q[sel_idx];
        occ_cnt = '0;
        for (int i = 0; i < DEPTH; i++) begin
            occ_cnt = occ_cnt + OCC_W'(used[i]);
        end
    end

    assign occupancy     = occ_cnt;
    assign iss_op        = sel_found ? sel_ent.op        : '0;
    assign iss_is_branch = sel_found ? sel_ent.is_branch : 1'b0;
    assign iss_pc_plus4  = sel_found ? sel_ent.pc_plus4  : '0;
    assign iss_vj        = sel_found ? sel_ent.vj        : '0;
    assign iss_vk        = sel_found ? sel_ent.vk        : '0;
    assign iss_dest      = sel_found ? sel_ent.dest      : '0;

endmodule

// File: tb/tb_ex_rs.sv
// Self-checking bench for ex_rs: directed vector table, hand sequences for
// full/flush/reset corners, and randomized traffic against a slot-array model.
module tb_ex_rs;

    localparam int DEPTH = 4;
    localparam int TAG_W = 4;
    localparam int OCC_W = $clog2(DEPTH) + 1;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic             reset, flush, disp_valid, disp_ready, disp_is_branch;
    logic [9:0]       disp_op;
    logic [31:0]      disp_pc_plus4, disp_vj, disp_vk, cdb_value;
    logic [TAG_W-1:0] disp_dest, disp_qj, disp_qk, cdb_tag;
    logic             disp_qj_busy, disp_qk_busy, cdb_valid;
    logic             iss_valid, iss_ready, iss_is_branch;
    logic [9:0]       iss_op;
    logic [31:0]      iss_pc_plus4, iss_vj, iss_vk;
    logic [TAG_W-1:0] iss_dest;
    logic [OCC_W-1:0] occupancy;

    ex_rs #(.DEPTH(DEPTH), .TAG_W(TAG_W)) dut (
        .clk(clk), .reset(reset), .flush(flush),
        .disp_valid(disp_valid), .disp_ready(disp_ready), .disp_op(disp_op),
        .disp_is_branch(disp_is_branch), .disp_pc_plus4(disp_pc_plus4), .disp_dest(disp_dest),
        .disp_qj_busy(disp_qj_busy), .disp_qj(disp_qj), .disp_vj(disp_vj),
        .disp_qk_busy(disp_qk_busy), .disp_qk(disp_qk), .disp_vk(disp_vk),
        .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_value(cdb_value),
        .iss_valid(iss_valid), .iss_ready(iss_ready), .iss_op(iss_op),
        .iss_is_branch(iss_is_branch), .iss_pc_plus4(iss_pc_plus4),
        .iss_vj(iss_vj), .iss_vk(iss_vk), .iss_dest(iss_dest), .occupancy(occupancy)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            if (n_fail <= 40) $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: one record per slot, updated from the spec's rules.
    typedef struct {
        bit               valid;
        logic [9:0]       op;
        logic             br;
        logic [31:0]      pc;
        logic [TAG_W-1:0] dest;
        bit               jb;
        logic [TAG_W-1:0] qj;
        logic [31:0]      vj;
        bit               kb;
        logic [TAG_W-1:0] qk;
        logic [31:0]      vk;
    } slot_t;

    slot_t m [DEPTH];
    initial for (int i = 0; i < DEPTH; i++) m[i].valid = 0;

    function automatic int m_pick();
        for (int i = 0; i < DEPTH; i++)
            if (m[i].valid && !m[i].jb && !m[i].kb) return i;
        return -1;
    endfunction

    function automatic int m_count();
        int c = 0;
        for (int i = 0; i < DEPTH; i++) if (m[i].valid) c++;
        return c;
    endfunction

    task automatic model_edge();
        int    pick, cnt, freeslot;
        slot_t n;
        if (reset || flush) begin
            for (int i = 0; i < DEPTH; i++) m[i].valid = 0;
            return;
        end
        pick = m_pick();
        cnt  = m_count();
        freeslot = -1;
        for (int i = DEPTH - 1; i >= 0; i--) if (!m[i].valid) freeslot = i;
        if (cdb_valid)
            for (int i = 0; i < DEPTH; i++) begin
                if (m[i].valid && m[i].jb && m[i].qj == cdb_tag) begin m[i].jb = 0; m[i].vj = cdb_value; end
                if (m[i].valid && m[i].kb && m[i].qk == cdb_tag) begin m[i].kb = 0; m[i].vk = cdb_value; end
            end
        if (pick >= 0 && iss_ready) m[pick].valid = 0;
        if (disp_valid && cnt < DEPTH) begin
            n.valid = 1; n.op = disp_op; n.br = disp_is_branch; n.pc = disp_pc_plus4;
            n.dest = disp_dest;
            n.jb = disp_qj_busy; n.qj = disp_qj; n.vj = disp_vj;
            n.kb = disp_qk_busy; n.qk = disp_qk; n.vk = disp_vk;
            if (cdb_valid && n.jb && n.qj == cdb_tag) begin n.jb = 0; n.vj = cdb_value; end
            if (cdb_valid && n.kb && n.qk == cdb_tag) begin n.kb = 0; n.vk = cdb_value; end
            m[freeslot] = n;
        end
    endtask

    task automatic model_check();
        int p = m_pick();
        chk("m_iss_valid", 32'(iss_valid), 32'(p >= 0));
        chk("m_occupancy", 32'(occupancy), 32'(m_count()));
        chk("m_disp_ready", 32'(disp_ready), 32'(m_count() < DEPTH));
        if (p >= 0) begin
            chk("m_iss_op", 32'(iss_op), 32'(m[p].op));
            chk("m_iss_br", 32'(iss_is_branch), 32'(m[p].br));
            chk("m_iss_pc", iss_pc_plus4, m[p].pc);
            chk("m_iss_vj", iss_vj, m[p].vj);
            chk("m_iss_vk", iss_vk, m[p].vk);
            chk("m_iss_dest", 32'(iss_dest), 32'(m[p].dest));
        end else begin
            chk("m_idle_data", {iss_vj ^ iss_vk ^ iss_pc_plus4}
                | 32'(iss_op) | 32'(iss_dest) | 32'(iss_is_branch), 32'd0);
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        model_edge();
        #1;
        model_check();
    endtask

    task automatic idle();
        reset = 0; flush = 0; disp_valid = 0; cdb_valid = 0; iss_ready = 0;
        disp_qj_busy = 0; disp_qk_busy = 0; disp_is_branch = 0;
        disp_op = '0; disp_pc_plus4 = '0; disp_dest = '0; disp_qj = '0; disp_qk = '0;
        disp_vj = '0; disp_vk = '0; cdb_tag = '0; cdb_value = '0;
    endtask

    task automatic disp(input logic [31:0] vj, input logic [31:0] vk, input logic [TAG_W-1:0] dest,
                        input logic jb, input logic [TAG_W-1:0] qj);
        disp_valid = 1; disp_vj = vj; disp_vk = vk; disp_dest = dest;
        disp_qj_busy = jb; disp_qj = qj; disp_qk_busy = 0; disp_qk = '0;
        disp_op = 10'(dest) + 10'h30; disp_pc_plus4 = 32'h400 + 32'(dest);
    endtask

    typedef struct {
        logic dv; logic [9:0] op; logic [TAG_W-1:0] dest;
        logic jb; logic [TAG_W-1:0] qj; logic [31:0] vj;
        logic kb; logic [TAG_W-1:0] qk; logic [31:0] vk;
        logic cv; logic [TAG_W-1:0] ct; logic [31:0] cval;
        logic ir;
        logic e_v; logic [31:0] e_vj; logic [31:0] e_vk; logic [TAG_W-1:0] e_dest;
        int e_occ; logic e_drdy;
    } vec_t;

    vec_t tbl [13];

    initial begin
        //             dv   op      dest  jb   qj    vj      kb   qk    vk     cv   ct    cval    ir   e_v  e_vj    e_vk   e_dest e_occ e_drdy
        tbl[0]  = '{1'b1,10'h000,4'd2,1'b0,4'd0,32'd5,  1'b0,4'd0,32'd7, 1'b0,4'd0,32'd0,  1'b1,1'b1,32'd5,  32'd7, 4'd2,  1, 1'b1};
        tbl[1]  = '{1'b0,10'h000,4'd0,1'b0,4'd0,32'd0,  1'b0,4'd0,32'd0, 1'b0,4'd0,32'd0,  1'b1,1'b0,32'd0,  32'd0, 4'd0,  0, 1'b1};
        tbl[2]  = '{1'b1,10'h011,4'd4,1'b1,4'd3,32'd0,  1'b0,4'd0,32'd2, 1'b0,4'd0,32'd0,  1'b1,1'b0,32'd0,  32'd0, 4'd0,  1, 1'b1};
        tbl[3]  = '{1'b0,10'h000,4'd0,1'b0,4'd0,32'd0,  1'b0,4'd0,32'd0, 1'b0,4'd0,32'd0,  1'b1,1'b0,32'd0,  32'd0, 4'd0,  1, 1'b1};
        tbl[4]  = '{1'b0,10'h000,4'd0,1'b0,4'd0,32'd0,  1'b0,4'd0,32'd0, 1'b1,4'd5,32'h99, 1'b1,1'b0,32'd0,  32'd0, 4'd0,  1, 1'b1};
        tbl[5]  = '{1'b0,10'h000,4'd0,1'b0,4'd0,32'd0,  1'b0,4'd0,32'd0, 1'b1,4'd3,32'h10, 1'b1,1'b1,32'h10, 32'd2, 4'd4,  1, 1'b1};
        tbl[6]  = '{1'b0,10'h000,4'd0,1'b0,4'd0,32'd0,  1'b0,4'd0,32'd0, 1'b0,4'd0,32'd0,  1'b1,1'b0,32'd0,  32'd0, 4'd0,  0, 1'b1};
        tbl[7]  = '{1'b1,10'h022,4'd7,1'b1,4'd6,32'd0,  1'b1,4'd6,32'd0, 1'b1,4'd6,32'hAB, 1'b0,1'b1,32'hAB, 32'hAB,4'd7,  1, 1'b1};
        tbl[8]  = '{1'b0,10'h000,4'd0,1'b0,4'd0,32'd0,  1'b0,4'd0,32'd0, 1'b0,4'd0,32'd0,  1'b0,1'b1,32'hAB, 32'hAB,4'd7,  1, 1'b1};
        tbl[9]  = '{1'b0,10'h000,4'd0,1'b0,4'd0,32'd0,  1'b0,4'd0,32'd0, 1'b0,4'd0,32'd0,  1'b1,1'b0,32'd0,  32'd0, 4'd0,  0, 1'b1};
        tbl[10] = '{1'b1,10'h033,4'd0,1'b1,4'd0,32'd0,  1'b0,4'd0,32'd1, 1'b0,4'd0,32'd0,  1'b1,1'b0,32'd0,  32'd0, 4'd0,  1, 1'b1};
        tbl[11] = '{1'b0,10'h000,4'd0,1'b0,4'd0,32'd0,  1'b0,4'd0,32'd0, 1'b1,4'd0,32'h55, 1'b1,1'b1,32'h55, 32'd1, 4'd0,  1, 1'b1};
        tbl[12] = '{1'b0,10'h000,4'd0,1'b0,4'd0,32'd0,  1'b0,4'd0,32'd0, 1'b0,4'd0,32'd0,  1'b1,1'b0,32'd0,  32'd0, 4'd0,  0, 1'b1};

        idle();
        reset = 1;
        cycle();
        cycle();
        reset = 0;
        chk("rst_iss_valid", 32'(iss_valid), 32'd0);
        chk("rst_disp_ready", 32'(disp_ready), 32'd1);
        chk("rst_occupancy", 32'(occupancy), 32'd0);

        for (int i = 0; i < 13; i++) begin
            idle();
            disp_valid = tbl[i].dv; disp_op = tbl[i].op; disp_dest = tbl[i].dest;
            disp_pc_plus4 = 32'h1000 + 32'(i * 4);
            disp_qj_busy = tbl[i].jb; disp_qj = tbl[i].qj; disp_vj = tbl[i].vj;
            disp_qk_busy = tbl[i].kb; disp_qk = tbl[i].qk; disp_vk = tbl[i].vk;
            cdb_valid = tbl[i].cv; cdb_tag = tbl[i].ct; cdb_value = tbl[i].cval;
            iss_ready = tbl[i].ir;
            cycle();
            chk($sformatf("v%0d_iss_valid", i), 32'(iss_valid), 32'(tbl[i].e_v));
            chk($sformatf("v%0d_iss_vj", i), iss_vj, tbl[i].e_vj);
            chk($sformatf("v%0d_iss_vk", i), iss_vk, tbl[i].e_vk);
            chk($sformatf("v%0d_iss_dest", i), 32'(iss_dest), 32'(tbl[i].e_dest));
            chk($sformatf("v%0d_occupancy", i), 32'(occupancy), 32'(tbl[i].e_occ));
            chk($sformatf("v%0d_disp_ready", i), 32'(disp_ready), 32'(tbl[i].e_drdy));
        end

        // Fill with issue stalled, then drain in index order.
        idle();
        for (int k = 0; k < 4; k++) begin
            disp(32'd100 + 32'(k), 32'(k), 4'(k), 1'b0, 4'd0);
            cycle();
        end
        chk("full_occupancy", 32'(occupancy), 32'd4);
        chk("full_disp_ready", 32'(disp_ready), 32'd0);
        chk("full_sel_vj", iss_vj, 32'd100);
        disp(32'd200, 32'd0, 4'd9, 1'b0, 4'd0);
        cycle();
        chk("fifth_ignored_occ", 32'(occupancy), 32'd4);
        disp(32'd300, 32'd0, 4'd10, 1'b0, 4'd0);
        iss_ready = 1;
        chk("drain0_vj", iss_vj, 32'd100);
        cycle();
        chk("full_swap_occ", 32'(occupancy), 32'd3);
        chk("full_swap_drdy", 32'(disp_ready), 32'd1);
        disp_valid = 0;
        for (int k = 1; k < 4; k++) begin
            chk($sformatf("drain%0d_vj", k), iss_vj, 32'd100 + 32'(k));
            chk($sformatf("drain%0d_dest", k), 32'(iss_dest), 32'(k));
            cycle();
        end
        chk("drained_occ", 32'(occupancy), 32'd0);
        chk("drained_valid", 32'(iss_valid), 32'd0);

        // Flush beats a same-cycle dispatch and a matching broadcast.
        idle();
        for (int k = 0; k < 3; k++) begin
            disp(32'd0, 32'd1, 4'(k), 1'b1, 4'd9);
            cycle();
        end
        chk("pre_flush_occ", 32'(occupancy), 32'd3);
        disp(32'd0, 32'd1, 4'd5, 1'b1, 4'd9);
        flush = 1; cdb_valid = 1; cdb_tag = 4'd9; cdb_value = 32'h77; iss_ready = 1;
        cycle();
        chk("flush_occ", 32'(occupancy), 32'd0);
        chk("flush_iss_valid", 32'(iss_valid), 32'd0);
        chk("flush_disp_ready", 32'(disp_ready), 32'd1);
        idle();
        cdb_valid = 1; cdb_tag = 4'd9;
        cycle();
        chk("post_flush_occ", 32'(occupancy), 32'd0);

        // Reset mid-operation overrides a dispatch.
        idle();
        for (int k = 0; k < 2; k++) begin
            disp(32'd50, 32'd60, 4'(k), 1'b0, 4'd0);
            cycle();
        end
        reset = 1;
        cycle();
        chk("midrst_occ", 32'(occupancy), 32'd0);
        chk("midrst_valid", 32'(iss_valid), 32'd0);
        idle();

        // Randomized traffic; small tag space to provoke wakeups and same-tag captures.
        for (int c = 0; c < 3000; c++) begin
            reset          = ($urandom_range(199) == 0);
            flush          = ($urandom_range(59) == 0);
            disp_valid     = $urandom_range(1) == 1;
            disp_op        = 10'($urandom);
            disp_is_branch = $urandom_range(1) == 1;
            disp_pc_plus4  = $urandom;
            disp_dest      = 4'($urandom);
            disp_qj_busy   = $urandom_range(2) != 0;
            disp_qj        = 4'($urandom_range(3));
            disp_vj        = $urandom;
            disp_qk_busy   = $urandom_range(2) != 0;
            disp_qk        = 4'($urandom_range(3));
            disp_vk        = $urandom;
            cdb_valid      = $urandom_range(2) != 0;
            cdb_tag        = 4'($urandom_range(3));
            cdb_value      = $urandom;
            iss_ready      = $urandom_range(3) != 0;
            cycle();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
